uart_rx: RTL
============

Name: uart_rx

Overview:
Asynchronous serial receiver (8N1 default) that deserialises a UART line into parallel bytes. It is the receiving end for the team's serial transmitter and is used as a sequential benchmark block, checked by a self-checking bench. It outputs each received byte with a one-cycle valid strobe and flags framing errors.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (even, >= 4)
DATA_BITS, 8, data bits per frame, LSB first

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
data_out  output  DATA_BITS  last correctly framed byte
valid  output  1  one-cycle pulse: data_out updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while not in IDLE

Behaviour:
- Reset (rst_n low at a clk edge): data_out=0, valid=0, frame_err=0, busy=0, state=IDLE, counters=0, synchroniser flops=1. Reset overrides everything, including mid-frame; the partial frame is discarded.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- Bit counter cnt: 0..CLKS_PER_BIT-1. Bit index idx: 0..DATA_BITS-1.
- IDLE: busy=0. If rx_s==0, go to START with cnt=0.
- START: count to CLKS_PER_BIT/2-1 (mid start bit). If rx_s==0 there, go to DATA with cnt=0, idx=0. Otherwise treat as a glitch and return to IDLE; no output pulse.
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift register bit idx (LSB first) and reset cnt. After idx==DATA_BITS-1 is sampled, go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
  - 1: data_out<=shift register, valid=1 for exactly one cycle, go to IDLE.
  - 0: frame_err=1 for one cycle, data_out unchanged, go to WAIT_HIGH.
- WAIT_HIGH (break/line-low recovery): busy=1. Go to IDLE when rx_s==1.
- valid and frame_err are never high in the same cycle. Both are registered outputs.
- Latency: valid rises (2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT) ±1 cycles after the first clk edge that sees rx low.
- Back-to-back frames: a start bit that begins immediately after the stop bit's nominal end is received. IDLE re-arms in the cycle after valid.
- rx held low forever: exactly one frame_err pulse, then the block stays in WAIT_HIGH.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: an even-parity bit follows the data bits, adding a PARITY state sampled like a data bit. An extra output port parity_err (1 bit, reset 0) pulses for one cycle with the stop-bit decision if parity mismatches. In that case data_out is not updated and valid is not asserted. A framing error takes precedence and parity_err stays 0. Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity_err port, and the frame is exactly start + DATA_BITS + stop.

Test Plan:
- Reset, rx=1 for 40 cycles -> data_out=0x00, valid=0, frame_err=0, busy=0.
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at CLKS_PER_BIT=16 -> single valid pulse within 154±1 cycles, data_out=0xA5, busy back to 0.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses 160 cycles apart; data_out=0x00 then 0xFF.
- Drive rx low for 4 cycles, then high -> no valid, no frame_err, busy returns to 0 within 12 cycles, data_out unchanged.
- Send 0x3C with stop bit=0, then hold rx=0 for 50 cycles, then rx=1 -> one frame_err pulse, no valid, data_out keeps its previous value. A following 0x3C frame gives valid with data_out=0x3C.
- Assert rst_n=0 for 1 cycle mid-data of 0x5A -> all outputs 0, no pulse for the aborted frame. Next frame 0x81 gives data_out=0x81. With UART_RX_PARITY_EN defined, 0x81 sent with parity=1 -> parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 2-flop synchronised UART receiver, LSB first, mid-bit sampling, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit (PARITY state) and the parity_err pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            // Line still low: wait for it to return high before re-arming.
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end else begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              parity_err_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif
  assign busy      = (state_q != S_IDLE);

endmodule
